// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter
// ---------------------------------------------------------------------------
// Shares the register file's single 32-to-1 read mux among NREQ requesters
// using a round-robin search. Each unstalled cycle at most one requester is
// granted: its register number is driven onto rf_sel, the combinational mux
// output (rf_data) is captured into the response register, and the response
// is presented with the winner's ID one cycle later.
//
// Optional feature macro: RFARB_XZR_EN
//   defined   -> a granted read of register 31 returns zero (XZR semantics);
//                grant, pointer update and rf_sel are unaffected
//   undefined -> register 31 behaves like any other register
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req_valid  in   [NREQ]       per-requester read request
//   req_addr   in   [NREQ][5]    per-requester register number
//   req_ready  out  [NREQ]       one-hot grant (zero while stalled)
//   rf_sel     out  [5]          register-file read mux select
//   rf_data    in   [WIDTH]      read mux output, combinational from rf_sel
//   stall      in   downstream not accepting; freezes the block
//   rsp_valid  out  response register holds valid data
//   rsp_id     out  [IDW]        requester owning the response
//   rsp_data   out  [WIDTH]      registered read data
// ---------------------------------------------------------------------------
module rf_read_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 64,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0][4:0]  req_addr,
    output logic [NREQ-1:0]       req_ready,
    output logic [4:0]            rf_sel,
    input  logic [WIDTH-1:0]      rf_data,
    input  logic                  stall,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data
);

    logic [IDW-1:0]   ptr_r;
    logic             rsp_valid_r;
    logic [IDW-1:0]   rsp_id_r;
    logic [WIDTH-1:0] rsp_data_r;

    logic             found_s;
    logic [IDW-1:0]   winner_s;
    logic [IDW:0]     idx_s;
    logic [NREQ-1:0]  grant_s;
    logic [4:0]       sel_s;
    logic [WIDTH-1:0] cap_data_s;
    logic [IDW-1:0]   ptr_next_s;

    // Round-robin search from ptr_r upward, wrapping at NREQ; first hit wins.
    // idx_s is one bit wider than an ID so ptr+offset never overflows before
    // the wrap subtraction.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        idx_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s = {1'b0, ptr_r} + (IDW+1)'(i);
            if (idx_s >= (IDW+1)'(NREQ)) begin
                idx_s = idx_s - (IDW+1)'(NREQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_valid[idx_s[IDW-1:0]]) begin
                found_s  = 1'b1;
                winner_s = idx_s[IDW-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant vector, mux select, captured data and next pointer for the winner.
    always_comb begin
        grant_s    = '0;
        sel_s      = 5'd0;
        ptr_next_s = ptr_r;
        if (found_s) begin
            grant_s[winner_s] = 1'b1;
            sel_s             = req_addr[winner_s];
            if (winner_s == IDW'(NREQ-1)) begin
                ptr_next_s = '0;
            end else begin
                ptr_next_s = winner_s + IDW'(1);
            end
        end else begin
            grant_s = '0;
        end
`ifdef RFARB_XZR_EN
        if (sel_s == 5'd31) begin
            cap_data_s = '0;
        end else begin
            cap_data_s = rf_data;
        end
`else
        cap_data_s = rf_data;
`endif
    end

    // Response register and round-robin pointer; everything holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= '0;
        end else if (!stall) begin
            if (found_s) begin
                rsp_valid_r <= 1'b1;
                rsp_id_r    <= winner_s;
                rsp_data_r  <= cap_data_s;
                ptr_r       <= ptr_next_s;
            end else begin
                rsp_valid_r <= 1'b0;
            end
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign req_ready = stall ? '0 : grant_s;
    assign rf_sel    = sel_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Testbench for rf_read_arbiter: directed scenarios followed by random
// traffic, checked against a behavioural round-robin model.
module tb_rf_read_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 64;
    localparam int IDW   = 2;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0][4:0] req_addr;
    logic [NREQ-1:0]      req_ready;
    logic [4:0]           rf_sel;
    logic [WIDTH-1:0]     rf_data;
    logic                 stall;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [WIDTH-1:0]     rsp_data;

    logic [WIDTH-1:0] rf_mem [32];

    int total = 0;
    int bad   = 0;

    // model state
    int               m_ptr;
    bit               m_vld;
    int               m_id;
    logic [WIDTH-1:0] m_data;
    bit               m_found;
    int               m_w;

    rf_read_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rf_sel(rf_sel), .rf_data(rf_data), .stall(stall),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    assign rf_data = rf_mem[rf_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_vld  = 0;
        m_id   = 0;
        m_data = '0;
    endtask

    // One clock: check combinational grant, clock it, check the response.
    task automatic step();
        logic [NREQ-1:0] exp_ready;
        logic [4:0]      exp_sel;
        #2;
        m_found = 0;
        m_w     = 0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (!m_found && req_valid[idx]) begin
                m_found = 1;
                m_w     = idx;
            end
        end
        exp_ready = (m_found && !stall) ? NREQ'(1 << m_w) : '0;
        exp_sel   = m_found ? req_addr[m_w] : 5'd0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("rf_sel", 64'(rf_sel), 64'(exp_sel));
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (!stall) begin
            if (m_found) begin
                m_vld = 1;
                m_id  = m_w;
`ifdef RFARB_XZR_EN
                m_data = (req_addr[m_w] == 5'd31) ? '0 : rf_mem[req_addr[m_w]];
`else
                m_data = rf_mem[req_addr[m_w]];
`endif
                m_ptr = (m_w + 1) % NREQ;
            end else begin
                m_vld = 0;
            end
        end
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(m_vld));
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_data", rsp_data, m_data);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom(), $urandom()};
        rf_mem[5]  = 64'h1234;
        rf_mem[31] = 64'hDEAD;
        model_reset();
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) req_addr[i] = 5'(i + 1);

        // Reset with every requester valid: nothing comes out.
        @(posedge clk); #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        step();
        reset = 1'b0;

        // Rotation 0,1,2,3,0 with responses one cycle behind.
        begin
            int order [5] = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) begin
                #2;
                chk("rr_order", 64'(req_ready), 64'(1 << order[i]));
                step();
                chk("rr_rsp_id", 64'(rsp_id), 64'(order[i]));
            end
        end

        // Requester 2 alone reads X5.
        req_valid = 4'b0100; req_addr[2] = 5'd5;
        #2;
        chk("solo_ready", 64'(req_ready), 64'b0100);
        chk("solo_sel", 64'(rf_sel), 64'd5);
        step();
        chk("solo_id", 64'(rsp_id), 64'd2);
        chk("solo_data", rsp_data, 64'h1234);

        // Pointer to 1, then 0 and 3 compete: 3 then 0 (wrap).
        req_valid = 4'b0001; step();
        req_valid = 4'b1001;
        #2; chk("wrap_first", 64'(req_ready), 64'b1000);
        step();
        #2; chk("wrap_second", 64'(req_ready), 64'b0001);
        step();

        // Grant requester 1, stall three cycles, then pending request is granted.
        req_valid = 4'b0010; req_addr[1] = 5'd9;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", 64'(req_ready), 64'd0);
            chk("stall_vld", 64'(rsp_valid), 64'd1);
            chk("stall_id", 64'(rsp_id), 64'd1);
            chk("stall_data", rsp_data, rf_mem[9]);
        end
        stall = 1'b0;
        #2; chk("unstall_ready", 64'(req_ready), 64'b0010);
        step();

        // Move pointer off zero, then asynchronous reset mid-operation.
        req_valid = 4'b0100; step();
        reset = 1'b1;
        #1;
        chk("arst_vld", 64'(rsp_valid), 64'd0);
        chk("arst_data", rsp_data, 64'd0);
        model_reset();
        req_valid = 4'b1111;
        step();
        reset = 1'b0;
        req_valid = 4'b0000;
        step();
        chk("post_rst_vld", 64'(rsp_valid), 64'd0);
        req_valid = 4'b1111;
        #2; chk("post_rst_ptr", 64'(req_ready), 64'b0001);
        step();

        // Register 31.
        req_valid = 4'b1000; req_addr[3] = 5'd31;
        #2; chk("x31_sel", 64'(rf_sel), 64'd31);
        step();
`ifdef RFARB_XZR_EN
        chk("x31_data", rsp_data, 64'd0);
`else
        chk("x31_data", rsp_data, 64'hDEAD);
`endif

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) req_addr[i] = 5'($urandom_range(0, 31));
            stall = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
